// File: rtl/mem_pkg.sv
// Shared definitions for the tiled byte-lane memory: FSM state type and
// helpers that derive the tile grid dimensions from the top-level parameters.
package mem_pkg;

   typedef enum logic {INIT, RUN} mem_state_t;

   // Number of tile rows needed to cover depth words (ceiling division).
   function automatic int unsigned n_rows(int unsigned depth, int unsigned tile_depth);
      return (depth + tile_depth - 1) / tile_depth;
   endfunction

   // Number of independently writable lanes in one word.
   function automatic int unsigned n_lanes(int unsigned width, int unsigned lane_w);
      return width / lane_w;
   endfunction

endpackage

// File: rtl/mem.sv
// Simple dual-port BRAM primitive used as the tile: port A writes, port B
// reads with one cycle of latency. No reset on the array or read register.
module mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clkA,
   input  logic             enA,
   input  logic             weA,
   input  logic [AW-1:0]    addrA,
   input  logic [WIDTH-1:0] dinA,
   input  logic             clkB,
   input  logic             enB,
   input  logic [AW-1:0]    addrB,
   output logic [WIDTH-1:0] doutB
);

   logic [WIDTH-1:0] ram_q [DEPTH];
   logic [WIDTH-1:0] dout_q;

   // Write port.
   always_ff @(posedge clkA) begin
      if (enA && weA) begin
         ram_q[addrA] <= dinA;
      end
   end

   // Registered read port.
   always_ff @(posedge clkB) begin
      if (enB) begin
         dout_q <= ram_q[addrB];
      end
   end

   assign doutB = dout_q;

endmodule

// File: rtl/mem_par_be.sv
// Byte-lane-writable buffer memory built from a grid of mem tiles (one column
// per lane, one row per TILE_DEPTH words). Adds zero-fill after reset,
// write-first collision bypass, a read-valid strobe and an optional output
// register.
module mem_par_be
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned DEPTH         = 512,
   parameter int unsigned LANE_W        = 8,
   parameter int unsigned TILE_DEPTH    = 1024,
   parameter int unsigned OUT_REG       = 0,
   parameter int unsigned INIT_ON_RESET = 1,
   localparam int unsigned N_LANES      = n_lanes(WIDTH, LANE_W),
   localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
   input  logic               clkB,
   input  logic               rst,
   input  logic               enA,
   input  logic [N_LANES-1:0] weA,
   input  logic [ADDR_W-1:0]  addrA,
   input  logic [WIDTH-1:0]   dinA,
   input  logic               enB,
   input  logic [ADDR_W-1:0]  addrB,
   output logic [WIDTH-1:0]   doutB,
   output logic               validB,
   output logic               init_busy
);

   localparam int unsigned N_ROWS  = n_rows(DEPTH, TILE_DEPTH);
   localparam int unsigned TILE_AW = $clog2(TILE_DEPTH);
   // Address width wide enough to hold both the word address and a tile offset.
   localparam int unsigned AW_EXT  = (ADDR_W > TILE_AW) ? ADDR_W : TILE_AW;

   mem_state_t         state_q, state_d;
   logic [TILE_AW-1:0] cnt_q, cnt_d;
   logic               init_wr;

   logic [AW_EXT-1:0]  a_ext, b_ext, a_row, b_row;
   logic               a_inr, b_inr;
   logic               wr_req, rd_req;

   logic [LANE_W-1:0]  tile_dout [N_ROWS][N_LANES];

   // Read-side pipeline aligned with the tile read latency.
   logic               rd_vld_q;
   logic               rd_inr_q;
   logic [AW_EXT-1:0]  rd_row_q;
   logic [N_LANES-1:0] byp_mask_q, byp_mask_d;
   logic [WIDTH-1:0]   byp_data_q;
   logic [WIDTH-1:0]   rd_data;

   assign a_ext = AW_EXT'(addrA);
   assign b_ext = AW_EXT'(addrB);
   assign a_row = a_ext >> TILE_AW;
   assign b_row = b_ext >> TILE_AW;
   assign a_inr = 32'(addrA) < DEPTH;
   assign b_inr = 32'(addrB) < DEPTH;

   // Requests are only honoured in RUN and never in a reset cycle.
   assign wr_req = (state_q == RUN) && !rst && enA && a_inr;
   assign rd_req = (state_q == RUN) && !rst && enB;

   assign init_busy = (state_q == INIT);

   // Next-state logic: INIT sweeps every tile offset once, then hands over to RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_wr = 1'b0;
      unique case (state_q)
         INIT: begin
            init_wr = !rst;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == TILE_AW'(TILE_DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // FSM state and init counter.
   always_ff @(posedge clkB) begin
      if (rst) begin
         state_q <= (INIT_ON_RESET != 0) ? INIT : RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      for (genvar l = 0; l < N_LANES; l++) begin : g_lane
         logic               t_en;
         logic [TILE_AW-1:0] t_addr;
         logic [LANE_W-1:0]  t_din;

         assign t_en   = init_wr || (wr_req && (a_row == AW_EXT'(r)) && weA[l]);
         assign t_addr = init_wr ? cnt_q : a_ext[TILE_AW-1:0];
         assign t_din  = init_wr ? '0 : dinA[l*LANE_W +: LANE_W];

         mem #(
            .WIDTH(LANE_W),
            .DEPTH(TILE_DEPTH)
         ) u_tile (
            .clkA (clkB),
            .enA  (t_en),
            .weA  (t_en),
            .addrA(t_addr),
            .dinA (t_din),
            .clkB (clkB),
            .enB  (rd_req),
            .addrB(b_ext[TILE_AW-1:0]),
            .doutB(tile_dout[r][l])
         );
      end
   end

   // Same-address write and read: lanes being written take the new data.
   assign byp_mask_d = (wr_req && rd_req && (addrA == addrB)) ? weA : '0;

   // Read pipeline stage and bypass capture.
   always_ff @(posedge clkB) begin
      if (rst) begin
         rd_vld_q   <= 1'b0;
         rd_inr_q   <= 1'b0;
         rd_row_q   <= '0;
         byp_mask_q <= '0;
         byp_data_q <= '0;
      end else begin
         rd_vld_q   <= rd_req;
         rd_inr_q   <= b_inr;
         rd_row_q   <= b_row;
         byp_mask_q <= byp_mask_d;
         byp_data_q <= dinA;
      end
   end

   // Row select, per-lane bypass and zero forcing for invalid or out-of-range reads.
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < N_ROWS; r++) begin
         if (rd_row_q == AW_EXT'(r)) begin
            for (int l = 0; l < N_LANES; l++) begin
               rd_data[l*LANE_W +: LANE_W] = tile_dout[r][l];
            end
         end
      end
      for (int l = 0; l < N_LANES; l++) begin
         if (byp_mask_q[l]) begin
            rd_data[l*LANE_W +: LANE_W] = byp_data_q[l*LANE_W +: LANE_W];
         end
      end
      if (!rd_vld_q || !rd_inr_q) begin
         rd_data = '0;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic             out_vld_q;
      logic [WIDTH-1:0] out_data_q;

      // Optional output register stage.
      always_ff @(posedge clkB) begin
         if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
         end else begin
            out_vld_q  <= rd_vld_q;
            out_data_q <= rd_data;
         end
      end

      assign validB = out_vld_q;
      assign doutB  = out_data_q;
   end else begin : g_out_comb
      assign validB = rd_vld_q;
      assign doutB  = rd_data;
   end

endmodule

// File: tb/tb_mem_par_be.sv
// Self-checking bench for mem_par_be: drives an OUT_REG=0 and an OUT_REG=1
// instance with identical stimulus and compares both against a word-level
// reference model every cycle, plus directed literal checks.
module tb_mem_par_be;

   localparam int unsigned W    = 32;
   localparam int unsigned D    = 3000;
   localparam int unsigned TD   = 1024;
   localparam int unsigned NL   = 4;
   localparam int unsigned MAXC = 16384;

   logic        clkB = 1'b0;
   logic        rst  = 1'b1;
   logic        enA  = 1'b0;
   logic        enB  = 1'b0;
   logic [3:0]  weA  = '0;
   logic [11:0] addrA = '0;
   logic [11:0] addrB = '0;
   logic [31:0] dinA = '0;

   logic [31:0] dout0, dout1;
   logic        vld0, vld1, busy0, busy1;

   always #5 clkB = ~clkB;

   mem_par_be #(
      .WIDTH(W), .DEPTH(D), .LANE_W(8), .TILE_DEPTH(TD), .OUT_REG(0), .INIT_ON_RESET(1)
   ) u_dut0 (
      .clkB(clkB), .rst(rst), .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA),
      .enB(enB), .addrB(addrB), .doutB(dout0), .validB(vld0), .init_busy(busy0)
   );

   mem_par_be #(
      .WIDTH(W), .DEPTH(D), .LANE_W(8), .TILE_DEPTH(TD), .OUT_REG(1), .INIT_ON_RESET(1)
   ) u_dut1 (
      .clkB(clkB), .rst(rst), .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA),
      .enB(enB), .addrB(addrB), .doutB(dout1), .validB(vld1), .init_busy(busy1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int p       = 0;

   // Reference model: word array, init countdown and per-edge read results.
   logic [31:0] mem_m [D];
   bit          busy_m = 1'b1;
   int          left_m = 0;
   bit          req_v  [MAXC];
   logic [31:0] req_d  [MAXC];
   bit          rst_at [MAXC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: update the model with the inputs sampled at this edge, then check.
   task automatic step();
      bit          v, v1;
      logic [31:0] d, d1;
      @(posedge clkB);
      p++;
      if (p >= int'(MAXC)) begin
         $display("FAIL cycle_budget observed=%0d expected<%0d", p, MAXC);
         $fatal(1);
      end
      v = 1'b0;
      d = '0;
      rst_at[p] = rst;
      if (rst) begin
         busy_m = 1'b1;
         left_m = TD;
      end else if (busy_m) begin
         left_m--;
         if (left_m == 0) begin
            busy_m = 1'b0;
            foreach (mem_m[i]) mem_m[i] = '0;
         end
      end else begin
         if (enA && addrA < D) begin
            for (int l = 0; l < int'(NL); l++) begin
               if (weA[l]) mem_m[addrA][8*l +: 8] = dinA[8*l +: 8];
            end
         end
         if (enB) begin
            v = 1'b1;
            d = (addrB < D) ? mem_m[addrB] : 32'h0;
         end
      end
      req_v[p] = v;
      req_d[p] = d;
      #1;
      v1 = (rst_at[p] || p < 2) ? 1'b0 : req_v[p-1];
      d1 = (rst_at[p] || p < 2) ? 32'h0 : req_d[p-1];
      check("busy0", 32'(busy0), 32'(busy_m));
      check("busy1", 32'(busy1), 32'(busy_m));
      check("valid0", 32'(vld0), 32'(v));
      check("dout0", dout0, d);
      check("valid1", 32'(vld1), 32'(v1));
      check("dout1", dout1, d1);
   endtask

   task automatic drv(input bit ea, input logic [3:0] we, input int aa, input logic [31:0] da,
                      input bit eb, input int ab);
      enA   = ea;
      weA   = we;
      addrA = 12'(aa);
      dinA  = da;
      enB   = eb;
      addrB = 12'(ab);
   endtask

   task automatic idle();
      drv(1'b0, 4'h0, 0, 32'h0, 1'b0, 0);
   endtask

   // Read with literal expectations at latency 1 (dut0) and 2 (dut1).
   task automatic rd_lit(input int a, input logic [31:0] e, input string tag);
      drv(1'b0, 4'h0, 0, 32'h0, 1'b1, a);
      step();
      check({tag, "_v0"}, 32'(vld0), 32'h1);
      check({tag, "_d0"}, dout0, e);
      idle();
      step();
      check({tag, "_v1"}, 32'(vld1), 32'h1);
      check({tag, "_d1"}, dout1, e);
   endtask

   // Counts init_busy cycles starting from the cycle rst deasserts.
   task automatic count_init(input bit poke, input string tag);
      int cnt;
      cnt = busy0 ? 1 : 0;
      rst = 1'b0;
      for (int i = 0; i < 2000 && busy0; i++) begin
         if (poke) drv(1'b1, 4'hF, 5, $urandom, 1'b1, 5);
         step();
         if (busy0) cnt++;
      end
      idle();
      check(tag, 32'(cnt), 32'd1024);
   endtask

   function automatic int pick();
      case ($urandom_range(0, 3))
         0:       return 1500;
         1:       return int'($urandom_range(0, 7) + $urandom_range(0, 2) * 1024);
         2:       return int'($urandom_range(2990, 3100));
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   initial begin
      int aa;
      idle();
      rst = 1'b1;
      step();
      step();
      count_init(1'b0, "init_len");
      rd_lit(2999, 32'h0, "rd2999_init");

      drv(1'b1, 4'hF, 1500, 32'hDEADBEEF, 1'b0, 0);
      step();
      rd_lit(1500, 32'hDEADBEEF, "full_wr");
      rd_lit(476, 32'h0, "row0_alias");
      rd_lit(2524, 32'h0, "row2_alias");

      drv(1'b1, 4'b0101, 1500, 32'h11223344, 1'b0, 0);
      step();
      rd_lit(1500, 32'hDE22BE44, "lane_wr");

      drv(1'b1, 4'b0011, 1500, 32'hCAFEF00D, 1'b1, 1500);
      step();
      check("collide_d0", dout0, 32'hDE22F00D);
      idle();
      step();
      check("collide_d1", dout1, 32'hDE22F00D);
      rd_lit(1500, 32'hDE22F00D, "after_collide");

      drv(1'b1, 4'hF, 3500, 32'hFFFFFFFF, 1'b0, 0);
      step();
      rd_lit(3500, 32'h0, "oor_rd");
      rd_lit(2999, 32'h0, "oor_no_alias");

      drv(1'b1, 4'h0, 1500, 32'h0, 1'b0, 0);
      step();
      rd_lit(1500, 32'hDE22F00D, "we_zero");

      // Back-to-back reads with no gaps.
      for (int i = 0; i < 6; i++) begin
         drv(1'b0, 4'h0, 0, 32'h0, 1'b1, (i % 2 == 0) ? 1500 : 2999 + i);
         step();
      end
      idle();

      // Randomized traffic biased towards collisions, lane edges and range limits.
      for (int i = 0; i < 600; i++) begin
         aa = pick();
         drv(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), aa, $urandom,
             1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? aa : pick());
         step();
      end
      idle();
      step();

      // Reset with a read in flight, then reset again partway through INIT.
      drv(1'b0, 4'h0, 0, 32'h0, 1'b1, 1500);
      step();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 500; i++) step();
      rst = 1'b1;
      step();
      step();
      count_init(1'b1, "reinit_len");
      rd_lit(5, 32'h0, "init_wr_ignored");
      rd_lit(1500, 32'h0, "reinit_zero");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_par_be.md
# mem_par_be

Single-clock, byte-lane-writable parametric memory that tiles `mem` BRAM primitives in both width (one tile column per byte lane) and depth (one tile row per `TILE_DEPTH` words). It adds capabilities the previous parametric memory did not have: per-lane write enables, an optional output register, a read-valid strobe, deterministic write-first collision handling and hardware zero-initialisation after reset. It serves as the generic buffer memory for datapath blocks that need partial-word updates.

## Interface
- `WIDTH`, 32: data width; must be a multiple of `LANE_W`.
- `DEPTH`, 512: words; any value ≥ 2, not necessarily a power of two.
- `LANE_W`, 8: bits per write-enable lane; `N_LANES = WIDTH/LANE_W`.
- `TILE_DEPTH`, 1024: words per `mem` tile, power of two; `N_ROWS = ceil(DEPTH/TILE_DEPTH)`.
- `OUT_REG`, 0: 1 adds an output register stage.
- `INIT_ON_RESET`, 1: 1 zero-fills the memory after reset.

Ports:
- `clkB`  in  1  sole clock for both ports.
- `rst`  in  1  reset, synchronous, active-high.
- `enA`  in  1  write-port enable.
- `weA`  in  N_LANES  per-lane write enable, qualified by `enA`.
- `addrA`  in  clog2(DEPTH)  write address.
- `dinA`  in  WIDTH  write data.
- `enB`  in  1  read request.
- `addrB`  in  clog2(DEPTH)  read address.
- `doutB`  out  WIDTH  read data; forced to 0 whenever `validB`=0.
- `validB`  out  1  `doutB` holds the result of a read request.
- `init_busy`  out  1  zero-fill in progress; all requests are ignored.

## Operation
- FSM states: INIT and RUN. `rst` moves the FSM to INIT if `INIT_ON_RESET`=1, otherwise to RUN.
- INIT:
  - An init counter runs 0..TILE_DEPTH-1.
  - Each cycle, every tile is written with zeros at the counter address, all lanes enabled.
  - After the counter reaches TILE_DEPTH-1, the FSM moves to RUN.
  - `enA` and `enB` are ignored; no `validB` is produced.
- Write (RUN): when `enA`=1 and `addrA` < DEPTH, row `addrA / TILE_DEPTH` is selected. Lane i of that row is written only where `weA[i]`=1. Other lanes and rows are untouched.
- Write with `addrA` ≥ DEPTH: the write is dropped silently.
- Read (RUN): when `enB`=1, the row index and the in-range flag are pipelined alongside the tile read. The output mux selects the row; an out-of-range read returns 0 with `validB`=1.
- Collision: `enA`, `enB` and `addrA`==`addrB` in the same cycle is write-first per lane. Lanes with `weA`=1 return `dinA`; other lanes return the stored data. A registered bypass implements this, so the result does not depend on the primitive's read-during-write mode.
- `enA`=1 with `weA`=0 is a no-op.

## Timing
- Read latency: request at cycle t gives `validB`/`doutB` at t+1 (`OUT_REG`=0) or t+2 (`OUT_REG`=1).
- Reads are fully pipelined, one per cycle, with no gaps. Writes complete in one cycle.
- Write at t, read of the same address at t+1 returns the new data.
- Reset values: `validB`=0, `doutB`=0, `init_busy`=`INIT_ON_RESET`; init counter 0.
- INIT lasts exactly TILE_DEPTH cycles after the cycle in which `rst` deasserts. `init_busy` falls in the first RUN cycle.
- `rst` asserted at any point:
  - In-flight reads are discarded (`validB`=0 from the next cycle).
  - INIT restarts from counter 0.
  - Memory contents are not otherwise cleared.
- A request presented while `init_busy`=1 is lost. The requester must wait for `init_busy`=0.

## Structure
- Shared package `mem_pkg`: the `mem_state_t` enum {INIT, RUN} and functions `n_rows(DEPTH, TILE_DEPTH)` and `n_lanes(WIDTH, LANE_W)`.
- The existing `mem` primitive is the tile (`WIDTH`=LANE_W, `DEPTH`=TILE_DEPTH, clkA=clkB=`clkB`), instantiated in an N_ROWS×N_LANES generate grid. No new sub-module is needed.
- The INIT write mux, read-side pipeline, bypass register and output register live in `mem_par_be`.

## Test plan
Configuration: `WIDTH`=32, `DEPTH`=3000, `LANE_W`=8, `TILE_DEPTH`=1024, run with `OUT_REG`=0 and with `OUT_REG`=1.
- Reset, then idle:
  - `init_busy`=1 for exactly 1024 cycles.
  - A read of 2999 then returns 0x00000000 with `validB`.
- Write 0xDEADBEEF to 1500 with `weA`=4'hF, read 1500 next cycle → 0xDEADBEEF at the configured latency. Reads of 476 and 2524 (same tile offset, other rows) return 0.
- Write 0x11223344 to 1500 with `weA`=4'b0101, read 1500 → 0xDE22BE44.
- Same-cycle write 0xCAFEF00D to 1500 with `weA`=4'b0011 and read 1500 → 0xDE22F00D. A following read of 1500 also returns 0xDE22F00D.
- Write 0xFFFFFFFF to 3500 (out of range), then read 3500 → 0, `validB`=1. A read of 2999 still returns 0.
- Assert `rst` at INIT cycle 500 → `init_busy` stays high for 1024 cycles after deassert. A write issued during INIT has no effect and no `validB` appears.
